// File: rtl/insn_fetch_sequencer.sv
// Instruction fetch/decode/execute/writeback sequencer. Issues one fetch per
// instruction, waits for the memory acknowledge with a bounded timeout, classifies
// the opcode into a one-hot code and strobes the execute and writeback phases.
// Illegal opcodes and fetch timeouts park the block in an absorbing trap state.
module insn_fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] pc_next,
    output logic [31:0] INSN,
    output logic [9:0]  Code,
    output logic [31:0] pc,
    output logic        exec_en,
    output logic        wb_en,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    typedef enum logic [2:0] {
        StFetch,
        StWait,
        StDecode,
        StExec,
        StWb,
        StTrap
    } state_e;

    localparam logic [31:0] InsnNop    = 32'h0000_0013;
    localparam logic [9:0]  CodeIalu   = 10'h080;
    localparam logic [9:0]  CodeIllg   = 10'h200;
    // Counter value seen in the last WAIT cycle that may still accept an ack.
    localparam logic [3:0]  TimeoutLast = 4'(ACK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] insn_q, insn_d;
    logic [9:0]  code_q, code_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        trap_q, trap_d;
    logic [1:0]  cause_q, cause_d;
    logic [9:0]  code_dec;

    // Opcode classification of the latched instruction.
    always_comb begin
        code_dec = CodeIllg;
        case (insn_q[6:0])
            7'b1101111: code_dec = 10'h001;
            7'b1100111: code_dec = 10'h002;
            7'b0110111: code_dec = 10'h004;
            7'b0010111: code_dec = 10'h008;
            7'b1100011: code_dec = 10'h010;
            7'b0110011: code_dec = 10'h020;
            7'b0100011: code_dec = 10'h040;
            7'b0010011: code_dec = 10'h080;
            7'b0000011: code_dec = 10'h100;
            default:    code_dec = CodeIllg;
        endcase
    end

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        insn_d  = insn_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        case (state_q)
            StFetch: state_d = StWait;
            StWait: begin
                // An ack in the final allowed cycle wins over the timeout.
                if (mem_ack) begin
                    insn_d  = mem_rdata;
                    cnt_d   = 4'd0;
                    state_d = StDecode;
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d   = cnt_q + 4'd1;
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDecode: begin
                code_d = code_dec;
                if (code_dec[9]) begin
                    trap_d  = 1'b1;
                    cause_d = 2'b01;
                    state_d = StTrap;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: state_d = StWb;
            StWb: begin
                pc_d    = pc_next;
                state_d = StFetch;
            end
            StTrap: state_d = StTrap;
            default: state_d = StTrap;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            insn_q  <= InsnNop;
            code_q  <= CodeIalu;
            cnt_q   <= 4'd0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // Phase strobes decoded from the state; the request is held off while in reset.
    always_comb begin
        mem_req    = ((state_q == StFetch) || (state_q == StWait)) && !RST;
        exec_en    = (state_q == StExec);
        wb_en      = (state_q == StWb);
        mem_addr   = pc_q;
        pc         = pc_q;
        INSN       = insn_q;
        Code       = code_q;
        trap       = trap_q;
        trap_cause = cause_q;
    end

endmodule

// File: tb/tb_insn_fetch_sequencer.sv
// Self-checking bench for insn_fetch_sequencer: directed scenarios plus random
// instruction streams compared against a transaction-level model.
module tb_insn_fetch_sequencer;

    localparam logic [31:0] RstPc   = 32'h0000_0080;
    localparam int          Timeout = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] pc_next = '0;
    logic [31:0] insn;
    logic [9:0]  code;
    logic [31:0] pc;
    logic        exec_en;
    logic        wb_en;
    logic        trap;
    logic [1:0]  trap_cause;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model state.
    logic [31:0] pc_m;
    logic [31:0] insn_m;
    logic [9:0]  code_m;

    always #5 clk = ~clk;

    insn_fetch_sequencer #(
        .RESET_PC   (RstPc),
        .ACK_TIMEOUT(Timeout)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .pc_next   (pc_next),
        .INSN      (insn),
        .Code      (code),
        .pc        (pc),
        .exec_en   (exec_en),
        .wb_en     (wb_en),
        .trap      (trap),
        .trap_cause(trap_cause)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] legal_op(input int idx);
        logic [6:0] ops [9];
        ops = '{7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1100011,
                7'b0110011, 7'b0100011, 7'b0010011, 7'b0000011};
        return ops[idx];
    endfunction

    // One-hot class: bit index of the opcode in the legal list, else bit 9.
    function automatic logic [9:0] class_of(input logic [6:0] op);
        for (int i = 0; i < 9; i++) begin
            if (op == legal_op(i)) return 10'(1) << i;
        end
        return 10'h200;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        check_val("strobe_onehot", 32'($countones({exec_en, wb_en, mem_req}) <= 1), 32'd1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
        tick();
        pc_m   = RstPc;
        insn_m = 32'h0000_0013;
        code_m = 10'h080;
        check_val("rst_insn", insn, insn_m);
        check_val("rst_code", 32'(code), 32'(code_m));
        check_val("rst_pc", pc, pc_m);
        check_val("rst_trap", {30'd0, trap_cause, trap}, 32'd0);
        check_val("rst_strobes", {29'd0, mem_req, exec_en, wb_en}, 32'd0);
        rst     = 1'b0;
        mem_ack = 1'b0;
        #1;
    endtask

    // Runs one instruction starting in the FETCH cycle. With ack = 0 the ack is
    // withheld for the full timeout window.
    task automatic run_insn(input int w, input bit ack, input logic [31:0] rdata,
                            input logic [31:0] pcn, output bit trapped);
        trapped = 1'b0;
        check_val("fetch_req", 32'(mem_req), 32'd1);
        check_val("fetch_addr", mem_addr, pc_m);
        mem_ack = 1'b0;
        tick();
        for (int i = 1; i <= w; i++) begin
            check_val("wait_req", 32'(mem_req), 32'd1);
            check_val("wait_trap", 32'(trap), 32'd0);
            if (ack && i == w) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = $urandom();
            end
            tick();
        end
        mem_ack = 1'b0;
        if (!ack) begin
            check_val("tmo_trap", {30'd0, trap_cause, trap}, {30'd0, 2'b10, 1'b1});
            check_val("tmo_req", 32'(mem_req), 32'd0);
            check_val("tmo_insn", insn, insn_m);
            check_val("tmo_pc", pc, pc_m);
            tick();
            check_val("tmo_hold", {29'd0, trap, mem_req, exec_en}, 32'd4);
            trapped = 1'b1;
            return;
        end
        insn_m = rdata;
        // DECODE: previous class still visible; a stray ack must be ignored.
        check_val("dec_strobes", {29'd0, mem_req, exec_en, wb_en}, 32'd0);
        check_val("dec_insn", insn, insn_m);
        check_val("dec_code_held", 32'(code), 32'(code_m));
        mem_ack   = 1'b1;
        mem_rdata = ~rdata;
        code_m    = class_of(rdata[6:0]);
        tick();
        mem_ack = 1'b0;
        if (code_m[9]) begin
            check_val("ill_trap", {30'd0, trap_cause, trap}, {30'd0, 2'b01, 1'b1});
            check_val("ill_code", 32'(code), 32'h200);
            check_val("ill_strobes", {29'd0, mem_req, exec_en, wb_en}, 32'd0);
            check_val("ill_insn", insn, insn_m);
            check_val("ill_pc", pc, pc_m);
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            check_val("ill_hold", {29'd0, trap, mem_req, exec_en}, 32'd4);
            check_val("ill_hold_insn", insn, insn_m);
            trapped = 1'b1;
            return;
        end
        check_val("exec_en", {30'd0, exec_en, wb_en}, 32'd2);
        check_val("exec_code", 32'(code), 32'(code_m));
        check_val("exec_insn", insn, insn_m);
        pc_next = pcn;
        tick();
        check_val("wb_en", {30'd0, exec_en, wb_en}, 32'd1);
        check_val("wb_pc_old", pc, pc_m);
        tick();
        pc_m = pcn;
        check_val("next_pc", pc, pc_m);
        check_val("next_trap", 32'(trap), 32'd0);
    endtask

    function automatic logic [31:0] rand_word(input logic [6:0] op);
        logic [31:0] r;
        r      = $urandom();
        r[6:0] = op;
        return r;
    endfunction

    initial begin
        bit tr;
        @(posedge clk);
        #1;
        do_reset();

        // Basic addi flow, then the next fetch uses the new pc.
        run_insn(1, 1'b1, 32'h0000_0513, 32'h4, tr);
        check_val("basic_code", 32'(code), 32'h080);
        check_val("basic_addr", mem_addr, 32'h4);
        check_val("basic_req", 32'(mem_req), 32'd1);

        // Opcode sweep over all legal classes, then an illegal one.
        for (int i = 0; i < 9; i++) begin
            run_insn(int'($urandom_range(1, 5)), 1'b1, rand_word(legal_op(i)), $urandom(), tr);
            check_val("sweep_code", 32'(code), 32'(10'(1) << i));
        end
        run_insn(2, 1'b1, rand_word(7'b1111111), $urandom(), tr);
        check_val("sweep_illegal", 32'(tr), 32'd1);
        do_reset();

        // Timeout: no ack for the whole window.
        run_insn(Timeout, 1'b0, '0, '0, tr);
        do_reset();

        // Ack in the last allowed WAIT cycle wins.
        run_insn(Timeout, 1'b1, rand_word(legal_op(5)), 32'h0000_1234, tr);
        check_val("late_ack_notrap", 32'(tr), 32'd0);

        // Reset during WAIT with a simultaneous ack.
        check_val("rw_fetch", 32'(mem_req), 32'd1);
        tick();
        tick();
        rst       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = rand_word(legal_op(0));
        tick();
        check_val("rw_insn", insn, 32'h0000_0013);
        check_val("rw_pc", pc, RstPc);
        check_val("rw_trap", 32'(trap), 32'd0);
        check_val("rw_req", 32'(mem_req), 32'd0);
        rst     = 1'b0;
        mem_ack = 1'b0;
        #1;
        check_val("rw_restart_req", 32'(mem_req), 32'd1);
        check_val("rw_restart_addr", mem_addr, RstPc);
        pc_m   = RstPc;
        insn_m = 32'h0000_0013;
        code_m = 10'h080;

        // PC wrap-around.
        run_insn(1, 1'b1, rand_word(legal_op(7)), 32'hFFFF_FFFC, tr);
        run_insn(3, 1'b1, rand_word(legal_op(1)), 32'h0000_0000, tr);
        check_val("wrap_pc", pc, 32'h0);
        check_val("wrap_trap", 32'(trap), 32'd0);

        // Random instruction stream.
        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            int         w;
            bit         ack;
            if ($urandom_range(0, 9) == 0) op = 7'($urandom());
            else op = legal_op(int'($urandom_range(0, 8)));
            ack = ($urandom_range(0, 19) != 0);
            w   = ack ? int'($urandom_range(1, Timeout)) : Timeout;
            run_insn(w, ack, rand_word(op), $urandom(), tr);
            if (tr) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/insn_fetch_sequencer.md
INSN_FETCH_SEQUENCER -- requirements
Module: insn_fetch_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: ACK_TIMEOUT, 15, maximum WAIT cycles allowed for mem_ack before a bus error.
REQ-003 CLK  input  1  single clock, rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 mem_req  output  1  instruction-fetch request, level.
REQ-006 mem_addr  output  32  fetch address, equal to pc.
REQ-007 mem_ack  input  1  fetch data valid, single-cycle pulse.
REQ-008 mem_rdata  input  32  fetched instruction word.
REQ-009 pc_next  input  32  next PC from the datapath.
REQ-010 INSN  output  32  latched instruction, fed to the instruction decoder.
REQ-011 Code  output  10  one-hot instruction class, fed to the instruction decoder.
REQ-012 pc  output  32  current PC.
REQ-013 exec_en  output  1  one-cycle execute-phase strobe.
REQ-014 wb_en  output  1  one-cycle writeback-phase strobe.
REQ-015 trap  output  1  sticky illegal-instruction or bus-error flag.
REQ-016 trap_cause  output  2  01 = illegal opcode, 10 = fetch timeout, 00 = none.

Function
REQ-017 The FSM SHALL have the states FETCH, WAIT, DECODE, EXEC, WB and TRAP.
REQ-018 FETCH SHALL assert mem_req with mem_addr = pc for one cycle, then go to WAIT.
REQ-019 WAIT SHALL hold mem_req high.
REQ-020 On mem_ack in WAIT, the block SHALL latch INSN = mem_rdata, drop mem_req the next cycle, clear the timeout counter, and go to DECODE.
REQ-021 A 4-bit timeout counter SHALL increment each WAIT cycle without mem_ack.
REQ-022 When the counter reaches ACK_TIMEOUT without mem_ack, the block SHALL go to TRAP with trap_cause = 10.
REQ-023 A mem_ack on the same cycle the counter reaches ACK_TIMEOUT SHALL win: the fetch completes and no trap is raised.
REQ-024 mem_ack outside WAIT SHALL be ignored.
REQ-025 In DECODE, Code SHALL be registered from INSN[6:0] as follows:
- 1101111 -> bit0 (J)
- 1100111 -> bit1 (jalr)
- 0110111 -> bit2 (lui)
- 0010111 -> bit3 (auipc)
- 1100011 -> bit4 (B)
- 0110011 -> bit5 (R)
- 0100011 -> bit6 (S)
- 0010011 -> bit7 (I-alu)
- 0000011 -> bit8 (I-load)
- any other value -> bit9 (illegal)
REQ-026 Code SHALL be valid from EXEC onward and held until the next DECODE.
REQ-027 When Code = bit9 after DECODE, the block SHALL go to TRAP with trap_cause = 01 instead of EXEC, and SHALL NOT assert exec_en.
REQ-028 EXEC SHALL assert exec_en for exactly one cycle, then go to WB.
REQ-029 WB SHALL assert wb_en for exactly one cycle, load pc <= pc_next, then go to FETCH.
REQ-030 The nominal instruction period SHALL be 4 + W cycles, where W is the number of WAIT cycles (W >= 1).
REQ-031 pc SHALL change only in WB and on reset; the full 32 bits are taken with no alignment check and wrap modulo 2^32.
REQ-032 TRAP SHALL be absorbing until RST, with trap = 1 and mem_req = exec_en = wb_en = 0.
REQ-033 In TRAP, INSN, Code and pc SHALL hold their last values.
REQ-034 Exactly one of exec_en, wb_en or mem_req, or none of them, SHALL be high in any cycle.

Reset
REQ-035 While RST is high at a rising CLK edge, the block SHALL load:
- state = FETCH
- pc = RESET_PC
- INSN = 32'h0000_0013 (nop)
- Code = 10'b00_1000_0000
- counter = 0
- trap = 0, trap_cause = 00
- mem_req = exec_en = wb_en = 0
REQ-036 RST asserted in any state, including TRAP or mid-WAIT, SHALL abort the fetch; a mem_ack arriving during RST is discarded.
REQ-037 The first cycle after RST deassertion SHALL be FETCH with mem_req = 1 and mem_addr = RESET_PC.

Verification
REQ-038 Release reset, ack with rdata = 32'h0000_0513 after 1 WAIT cycle, pc_next = 4 -> Code = 10'h080, exec_en then wb_en on consecutive cycles, pc = 4, next mem_addr = 4.
REQ-039 Sweep all nine legal opcodes plus 7'b1111111 -> correct one-hot Code for each; 1111111 gives Code = 10'h200, trap = 1, trap_cause = 01, no exec_en.
REQ-040 Withhold mem_ack for 15 WAIT cycles -> trap = 1, trap_cause = 10, mem_req = 0 from the next cycle.
REQ-041 Ack on exactly the 15th WAIT cycle -> no trap, DECODE follows.
REQ-042 Assert RST during WAIT with a simultaneous mem_ack -> INSN = nop, pc = RESET_PC, FETCH restarts, trap = 0.
REQ-043 Load pc_next = 32'hFFFF_FFFC then 32'h0000_0000 -> pc takes both values, with wrap-around and no trap.
